// File: rtl/pipe_latch_skid.sv
// Pipeline stage latch with valid/ready handshake, one output entry plus one skid entry.
// in_ready comes from registered state (plus flush/rst), never from out_ready.
module pipe_latch_skid #(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] RESET_VAL      = '0,
    parameter bit               CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             full_q;
    logic             in_xfer, out_xfer;

    assign full_q    = (state_q == FULL);
    assign in_ready  = ~full_q & ~flush & ~rst;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // An output transfer in this cycle is still delivered; only held entries are dropped.
            state_d = EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_d = RESET_VAL;
                skid_d = RESET_VAL;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (in_xfer) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Directed table-driven bench for pipe_latch_skid: default instance plus a WIDTH=5,
// CLEAR_ON_FLUSH=0 instance exercised by a short hand-written sequence.
module tb_pipe_latch_skid;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance, RESET_VAL=0, CLEAR_ON_FLUSH=1
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    pipe_latch_skid #(.WIDTH(32), .RESET_VAL(32'h0), .CLEAR_ON_FLUSH(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    // 5-bit instance, data held on flush
    logic       b_rst, b_in_valid, b_flush, b_out_ready;
    logic [4:0] b_in_data;
    logic       b_in_ready, b_out_valid;
    logic [4:0] b_out_data;
    logic [1:0] b_occupancy;

    pipe_latch_skid #(.WIDTH(5), .RESET_VAL(5'h0), .CLEAR_ON_FLUSH(1'b0)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occupancy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] id;
        logic        fl;
        logic        ordy;
        logic        ov;
        logic [31:0] od;
        logic [1:0]  occ;
        logic        ir;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic iv, input logic [31:0] id, input logic fl,
                       input logic ordy, input logic ov, input logic [31:0] od,
                       input logic [1:0] occ, input logic ir);
        vec_t v;
        v.rst = r; v.iv = iv; v.id = id; v.fl = fl; v.ordy = ordy;
        v.ov = ov; v.od = od; v.occ = occ; v.ir = ir;
        tbl.push_back(v);
    endtask

    initial begin
        // Each row: inputs applied for one cycle; expectations are the outputs
        // seen in that cycle before its rising edge.
        //   rst iv  id            fl ordy  ov  od            occ ir
        add(1, 1, 32'hDEADBEEF, 0, 0,    0, 32'h0,        0, 0);  // 0 reset held
        add(0, 0, 32'h0,        0, 1,    0, 32'h0,        0, 1);  // 1 out of reset
        add(0, 1, 32'h1,        0, 1,    0, 32'h0,        0, 1);  // 2 stream 1
        add(0, 1, 32'h2,        0, 1,    1, 32'h1,        1, 1);  // 3 stream 2
        add(0, 1, 32'h3,        0, 1,    1, 32'h2,        1, 1);  // 4 stream 3
        add(0, 0, 32'h0,        0, 1,    1, 32'h3,        1, 1);  // 5 drain
        add(0, 0, 32'h0,        0, 0,    0, 32'h3,        0, 1);  // 6 empty keeps last
        add(0, 1, 32'hA,        0, 0,    0, 32'h3,        0, 1);  // 7 bp A
        add(0, 1, 32'hB,        0, 0,    1, 32'hA,        1, 1);  // 8 bp B -> skid
        add(0, 1, 32'hC,        0, 0,    1, 32'hA,        2, 0);  // 9 full, C refused
        add(0, 0, 32'h0,        0, 1,    1, 32'hA,        2, 0);  // 10 OT A
        add(0, 0, 32'h0,        0, 1,    1, 32'hB,        1, 1);  // 11 OT B
        add(0, 0, 32'h0,        0, 0,    0, 32'hB,        0, 1);  // 12 empty
        add(0, 1, 32'h5,        0, 0,    0, 32'hB,        0, 1);  // 13 fill 5
        add(0, 1, 32'h6,        0, 0,    1, 32'h5,        1, 1);  // 14 fill 6
        add(0, 1, 32'h7,        1, 0,    1, 32'h5,        2, 0);  // 15 flush, 7 offered
        add(0, 0, 32'h0,        0, 0,    0, 32'h0,        0, 1);  // 16 flushed, cleared
        add(0, 1, 32'h8,        0, 1,    0, 32'h0,        0, 1);  // 17 accept 8
        add(0, 1, 32'h9,        1, 1,    1, 32'h8,        1, 0);  // 18 flush w/ OT of 8
        add(0, 0, 32'h0,        0, 1,    0, 32'h0,        0, 1);  // 19 9 not taken
        add(0, 1, 32'h11,       0, 0,    0, 32'h0,        0, 1);  // 20 fill 11
        add(0, 1, 32'h22,       0, 0,    1, 32'h11,       1, 1);  // 21 fill 22
        add(1, 1, 32'h33,       1, 1,    1, 32'h11,       2, 0);  // 22 rst+flush when full
        add(0, 0, 32'h0,        0, 1,    0, 32'h0,        0, 1);  // 23 after reset
        add(0, 0, 32'h0,        0, 1,    0, 32'h0,        0, 1);  // 24 no stray output

        rst = 1; in_valid = 1; in_data = 32'hDEADBEEF; flush = 0; out_ready = 0;
        b_rst = 1; b_in_valid = 0; b_in_data = 5'h0; b_flush = 0; b_out_ready = 0;
        @(negedge clk);
        chk("rst_in_ready_first", {31'b0, in_ready}, 32'h0);
        @(posedge clk);
        @(negedge clk);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].id;
            flush = tbl[i].fl; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("row%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ov});
            chk($sformatf("row%0d_out_data", i), out_data, tbl[i].od);
            chk($sformatf("row%0d_occupancy", i), {30'b0, occupancy}, {30'b0, tbl[i].occ});
            chk($sformatf("row%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].ir});
            @(posedge clk);
            @(negedge clk);
        end

        // Second instance: flush must not clear held data.
        b_rst = 0; b_in_valid = 1; b_in_data = 5'h1F; b_out_ready = 0;
        #1;
        chk("b_after_rst_ready", {31'b0, b_in_ready}, 32'h1);
        chk("b_after_rst_data", {27'b0, b_out_data}, 32'h0);
        @(posedge clk); @(negedge clk);
        b_in_valid = 1; b_in_data = 5'h03;
        #1;
        chk("b_hold_valid", {31'b0, b_out_valid}, 32'h1);
        chk("b_hold_data", {27'b0, b_out_data}, 32'h1F);
        @(posedge clk); @(negedge clk);
        b_in_valid = 0; b_flush = 1;
        #1;
        chk("b_full_occ", {30'b0, b_occupancy}, 32'h2);
        chk("b_flush_ready", {31'b0, b_in_ready}, 32'h0);
        @(posedge clk); @(negedge clk);
        b_flush = 0;
        #1;
        chk("b_flushed_valid", {31'b0, b_out_valid}, 32'h0);
        chk("b_flushed_occ", {30'b0, b_occupancy}, 32'h0);
        chk("b_flushed_data", {27'b0, b_out_data}, 32'h1F);
        chk("b_flushed_ready", {31'b0, b_in_ready}, 32'h1);
        b_in_valid = 1; b_in_data = 5'h04; b_out_ready = 1;
        @(posedge clk); @(negedge clk);
        b_in_valid = 0;
        #1;
        chk("b_refill_data", {27'b0, b_out_data}, 32'h04);
        chk("b_refill_occ", {30'b0, b_occupancy}, 32'h1);
        @(posedge clk); @(negedge clk);
        #1;
        chk("b_drained_valid", {31'b0, b_out_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
